// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared intersection types: scheduler states, default
//                pedestrian timings and lamp encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WALK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    localparam int c_def_num_xing   = 4;
    localparam int c_def_walk_time  = 7;
    localparam int c_def_clear_time = 5;
    localparam int c_def_gap_time   = 10;

    // Encoding matches the lamp driver inside the light controller.
    typedef enum logic [1:0] {
        LAMP_DONT_WALK = 2'd0,
        LAMP_WALK      = 2'd1,
        LAMP_FLASH     = 2'd2
    } ped_lamp_t;

    function automatic ped_lamp_t lamp_for_state(input sched_state_t s);
        ped_lamp_t l;
        case (s)
            ST_WALK:  l = LAMP_WALK;
            ST_CLEAR: l = LAMP_FLASH;
            default:  l = LAMP_DONT_WALK;
        endcase
        return l;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_crossing_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ped_crossing_scheduler_if
//  Description : Button, controller handshake and lamp bundle of the
//                pedestrian scheduler. emerg exists with EMERGENCY_PREEMPT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ped_crossing_scheduler_if
    import traffic_pkg::*;
#(
    parameter int NUM_XING = c_def_num_xing
);
    logic [NUM_XING-1:0] ped_btn;
    logic                ctrl_all_red;
`ifdef EMERGENCY_PREEMPT_EN
    logic                emerg;
`endif
    logic                hold;
    logic [NUM_XING-1:0] walk;
    logic [NUM_XING-1:0] flash;
    logic [NUM_XING-1:0] pending;
    logic                busy;

    modport master (
`ifdef EMERGENCY_PREEMPT_EN
        output emerg,
`endif
        output ped_btn,
        output ctrl_all_red,
        input  hold,
        input  walk,
        input  flash,
        input  pending,
        input  busy
    );

    modport slave (
`ifdef EMERGENCY_PREEMPT_EN
        input  emerg,
`endif
        input  ped_btn,
        input  ctrl_all_red,
        output hold,
        output walk,
        output flash,
        output pending,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick; searches from i_ptr+1 with
//                wrap-around and returns a one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic [N-1:0]         i_req,
    input  wire logic [$clog2(N)-1:0] i_ptr,
    output logic      [N-1:0]         o_grant,
    output logic                      o_valid
);
    localparam int c_ptr_w = $clog2(N);

    logic [c_ptr_w-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = c_ptr_w'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ped_crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ped_crossing_scheduler
//  Description : Latches walk requests, holds the light controller in all-red
//                and serves one crossing per walk/clear/gap round.
//                Optional EMERGENCY_PREEMPT_EN adds the emerg preemption input.
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing_scheduler
    import traffic_pkg::*;
#(
    parameter int NUM_XING   = c_def_num_xing,
    parameter int WALK_TIME  = c_def_walk_time,
    parameter int CLEAR_TIME = c_def_clear_time,
    parameter int GAP_TIME   = c_def_gap_time
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    ped_crossing_scheduler_if.slave   bus
);
    localparam int c_idx_w = $clog2(NUM_XING);
    localparam int c_cnt_w = $clog2(max3(WALK_TIME, CLEAR_TIME, GAP_TIME) + 1);
    localparam logic [c_cnt_w-1:0] c_walk_load  = c_cnt_w'(WALK_TIME - 1);
    localparam logic [c_cnt_w-1:0] c_clear_load = c_cnt_w'(CLEAR_TIME - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_TIME - 1);
    localparam logic [NUM_XING-1:0] c_one       = {{(NUM_XING-1){1'b0}}, 1'b1};

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_idx_w-1:0]  r_ptr;
    logic [c_idx_w-1:0]  r_grant;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic [NUM_XING-1:0] r_pending;
    logic [NUM_XING-1:0] w_pick_oh;
    logic [NUM_XING-1:0] w_grant_oh;
    logic [NUM_XING-1:0] w_walk;
    logic [NUM_XING-1:0] w_flash;
    logic [NUM_XING-1:0] w_clr_mask;
    logic                w_pick_valid;
    logic                w_take;
    logic                w_emerg;
    ped_lamp_t           w_lamp;

`ifdef EMERGENCY_PREEMPT_EN
    assign w_emerg = bus.emerg;
`else
    assign w_emerg = 1'b0;
`endif

    rr_arbiter #(
        .N (NUM_XING)
    ) u_arb (
        .i_req   (r_pending),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_XING; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_idx = c_idx_w'(i);
            end
        end
    end

    // Emergency has priority over a grant in REQ and cuts WALK short,
    // but CLEAR always runs its full length.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending != '0) && !w_emerg) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_emerg) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_gap_load;
                end else if (bus.ctrl_all_red && w_pick_valid) begin
                    w_state_nxt = ST_WALK;
                    w_cnt_nxt   = c_walk_load;
                    w_take      = 1'b1;
                end
            end
            ST_WALK: begin
                if (w_emerg || (r_cnt == '0)) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = c_clear_load;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_gap_load;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ((r_pending != '0) && !w_emerg) ? ST_REQ : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_clr_mask = w_take ? w_pick_oh : '0;

    // Presses on the crossing that is walking are dropped; the grant clear
    // wins over a press landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ptr     <= c_idx_w'(NUM_XING - 1);
            r_grant   <= '0;
            r_pending <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pending <= (r_pending | (bus.ped_btn & ~w_walk)) & ~w_clr_mask;
            if (w_take) begin
                r_ptr   <= w_pick_idx;
                r_grant <= w_pick_idx;
            end
        end
    end

    assign w_lamp     = lamp_for_state(r_state);
    assign w_grant_oh = c_one << r_grant;
    assign w_walk     = (w_lamp == LAMP_WALK)  ? w_grant_oh : '0;
    assign w_flash    = (w_lamp == LAMP_FLASH) ? w_grant_oh : '0;

    assign bus.walk    = w_walk;
    assign bus.flash   = w_flash;
    assign bus.hold    = (r_state == ST_REQ) || (r_state == ST_WALK) || (r_state == ST_CLEAR);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.pending = r_pending;
endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ped_crossing_scheduler
//  Description : Scoreboard bench: scenarios queue hand-computed output
//                snapshots by cycle; the monitor checks them and flags any
//                output change that was not predicted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_crossing_scheduler;

    typedef struct packed {
        logic       hold;
        logic [3:0] walk;
        logic [3:0] flash;
        logic [3:0] pending;
        logic       busy;
    } obs_t;

    typedef struct {
        int    cyc;
        string tag;
        obs_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   base = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    bit   flushed = 1'b0;
    bit   have_prev = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    obs_t cur;
    obs_t prev;

    ped_crossing_scheduler_if #(.NUM_XING(4)) bus_if ();

    ped_crossing_scheduler #(
        .NUM_XING   (4),
        .WALK_TIME  (7),
        .CLEAR_TIME (5),
        .GAP_TIME   (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int rel, input string tag, input logic h,
                            input logic [3:0] w, input logic [3:0] f,
                            input logic [3:0] p, input logic b);
        exp_t x;
        x.cyc = base + rel;
        x.tag = tag;
        x.v   = {h, w, f, p, b};
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {bus_if.hold, bus_if.walk, bus_if.flash, bus_if.pending, bus_if.busy};
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                if (e.cyc != cyc || cur !== e.v) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d (due %0d): got h=%b w=%b f=%b p=%b b=%b, want h=%b w=%b f=%b p=%b b=%b",
                             e.tag, cyc, e.cyc, cur.hold, cur.walk, cur.flash, cur.pending, cur.busy,
                             e.v.hold, e.v.walk, e.v.flash, e.v.pending, e.v.busy);
                end
            end else if (have_prev && cur !== prev) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_change @cyc %0d: got h=%b w=%b f=%b p=%b b=%b, want unchanged h=%b w=%b f=%b p=%b b=%b",
                         cyc, cur.hold, cur.walk, cur.flash, cur.pending, cur.busy,
                         prev.hold, prev.walk, prev.flash, prev.pending, prev.busy);
            end
            prev      = cur;
            have_prev = 1'b1;
            if (done && !flushed) begin
                while (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    n_bad++;
                    $display("FAIL %s never checked: due cyc %0d, now cyc %0d", e.tag, e.cyc, cyc);
                end
                flushed = 1'b1;
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus_if.ped_btn      = 4'b0000;
        bus_if.ctrl_all_red = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        bus_if.emerg        = 1'b0;
`endif
        // Reset, then 50 quiet cycles with no request.
        base = 0;
        push_exp(1,  "reset",        0, 4'b0000, 4'b0000, 4'b0000, 0);
        push_exp(52, "idle_no_hold", 0, 4'b0000, 4'b0000, 4'b0000, 0);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(50);

        // Round robin: 1011 at once, fresh press on 0 during the first CLEAR.
        base = cyc;
        bus_if.ctrl_all_red = 1'b1;
        push_exp(1,  "rr_latch",   0, 4'b0000, 4'b0000, 4'b1011, 0);
        push_exp(2,  "rr_req1",    1, 4'b0000, 4'b0000, 4'b1011, 1);
        push_exp(3,  "rr_walk0",   1, 4'b0001, 4'b0000, 4'b1010, 1);
        push_exp(10, "rr_flash0",  1, 4'b0000, 4'b0001, 4'b1010, 1);
        push_exp(11, "rr_repress", 1, 4'b0000, 4'b0001, 4'b1011, 1);
        push_exp(15, "rr_gap1",    0, 4'b0000, 4'b0000, 4'b1011, 1);
        push_exp(25, "rr_req2",    1, 4'b0000, 4'b0000, 4'b1011, 1);
        push_exp(26, "rr_walk1",   1, 4'b0010, 4'b0000, 4'b1001, 1);
        push_exp(33, "rr_flash1",  1, 4'b0000, 4'b0010, 4'b1001, 1);
        push_exp(38, "rr_gap2",    0, 4'b0000, 4'b0000, 4'b1001, 1);
        push_exp(48, "rr_req3",    1, 4'b0000, 4'b0000, 4'b1001, 1);
        push_exp(49, "rr_walk3",   1, 4'b1000, 4'b0000, 4'b0001, 1);
        push_exp(56, "rr_flash3",  1, 4'b0000, 4'b1000, 4'b0001, 1);
        push_exp(61, "rr_gap3",    0, 4'b0000, 4'b0000, 4'b0001, 1);
        push_exp(71, "rr_req4",    1, 4'b0000, 4'b0000, 4'b0001, 1);
        push_exp(72, "rr_walk0b",  1, 4'b0001, 4'b0000, 4'b0000, 1);
        push_exp(79, "rr_flash0b", 1, 4'b0000, 4'b0001, 4'b0000, 1);
        push_exp(84, "rr_gap4",    0, 4'b0000, 4'b0000, 4'b0000, 1);
        push_exp(94, "rr_idle",    0, 4'b0000, 4'b0000, 4'b0000, 0);
        bus_if.ped_btn = 4'b1011;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(9);
        bus_if.ped_btn = 4'b0001;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(85);

        // Single request on crossing 2 with the controller already all-red.
        base = cyc;
        push_exp(1,  "one_latch", 0, 4'b0000, 4'b0000, 4'b0100, 0);
        push_exp(2,  "one_hold",  1, 4'b0000, 4'b0000, 4'b0100, 1);
        push_exp(3,  "one_walk",  1, 4'b0100, 4'b0000, 4'b0000, 1);
        push_exp(10, "one_flash", 1, 4'b0000, 4'b0100, 4'b0000, 1);
        push_exp(15, "one_gap",   0, 4'b0000, 4'b0000, 4'b0000, 1);
        push_exp(25, "one_idle",  0, 4'b0000, 4'b0000, 4'b0000, 0);
        bus_if.ped_btn = 4'b0100;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(26);

        // Controller not ready for 20 cycles; press on grant edge and during
        // WALK is dropped; all-red falling mid-walk does not disturb anything.
        base = cyc;
        bus_if.ctrl_all_red = 1'b0;
        push_exp(1,  "wait_latch", 0, 4'b0000, 4'b0000, 4'b0010, 0);
        push_exp(2,  "wait_hold",  1, 4'b0000, 4'b0000, 4'b0010, 1);
        push_exp(21, "wait_still", 1, 4'b0000, 4'b0000, 4'b0010, 1);
        push_exp(22, "wait_walk",  1, 4'b0010, 4'b0000, 4'b0000, 1);
        push_exp(29, "wait_flash", 1, 4'b0000, 4'b0010, 4'b0000, 1);
        push_exp(34, "wait_gap",   0, 4'b0000, 4'b0000, 4'b0000, 1);
        push_exp(44, "wait_idle",  0, 4'b0000, 4'b0000, 4'b0000, 0);
        bus_if.ped_btn = 4'b0010;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(20);
        bus_if.ctrl_all_red = 1'b1;
        bus_if.ped_btn      = 4'b0010;
        step(2);
        bus_if.ctrl_all_red = 1'b0;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(22);

        // Reset during the third walk cycle drops the pending request too.
        base = cyc;
        bus_if.ctrl_all_red = 1'b1;
        push_exp(1,  "rst_latch",   0, 4'b0000, 4'b0000, 4'b1000, 0);
        push_exp(2,  "rst_hold",    1, 4'b0000, 4'b0000, 4'b1000, 1);
        push_exp(3,  "rst_walk",    1, 4'b1000, 4'b0000, 4'b0000, 1);
        push_exp(4,  "rst_pend0",   1, 4'b1000, 4'b0000, 4'b0001, 1);
        push_exp(6,  "rst_clears",  0, 4'b0000, 4'b0000, 4'b0000, 0);
        push_exp(11, "rst_quiet",   0, 4'b0000, 4'b0000, 4'b0000, 0);
        bus_if.ped_btn = 4'b1000;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(2);
        bus_if.ped_btn = 4'b0001;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);

`ifdef EMERGENCY_PREEMPT_EN
        // Emergency on walk cycle 2: full clear, gap, then parked in IDLE.
        base = cyc;
        push_exp(1,  "em_latch",   0, 4'b0000, 4'b0000, 4'b0100, 0);
        push_exp(2,  "em_hold",    1, 4'b0000, 4'b0000, 4'b0100, 1);
        push_exp(3,  "em_walk",    1, 4'b0100, 4'b0000, 4'b0000, 1);
        push_exp(5,  "em_flash",   1, 4'b0000, 4'b0100, 4'b0000, 1);
        push_exp(6,  "em_press0",  1, 4'b0000, 4'b0100, 4'b0001, 1);
        push_exp(10, "em_gap",     0, 4'b0000, 4'b0000, 4'b0001, 1);
        push_exp(20, "em_park",    0, 4'b0000, 4'b0000, 4'b0001, 0);
        push_exp(24, "em_noreq",   0, 4'b0000, 4'b0000, 4'b0001, 0);
        push_exp(25, "em_req",     1, 4'b0000, 4'b0000, 4'b0001, 1);
        push_exp(26, "em_walk0",   1, 4'b0001, 4'b0000, 4'b0000, 1);
        push_exp(33, "em_flash0",  1, 4'b0000, 4'b0001, 4'b0000, 1);
        push_exp(38, "em_gap0",    0, 4'b0000, 4'b0000, 4'b0000, 1);
        push_exp(48, "em_idle",    0, 4'b0000, 4'b0000, 4'b0000, 0);
        bus_if.ped_btn = 4'b0100;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(3);
        bus_if.emerg = 1'b1;
        step(1);
        bus_if.ped_btn = 4'b0001;
        step(1);
        bus_if.ped_btn = 4'b0000;
        step(18);
        bus_if.emerg = 1'b0;
        step(26);
`endif

        done = 1'b1;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
